// File: rtl/arm_pkg.sv
// Shared encodings, widths and control payload for the ARM-subset decoder.
// Optional illegal-instruction detection is enabled with DECODER_ILLEGAL_EN.
package arm_pkg;

   localparam int unsigned OP_W      = 2;
   localparam int unsigned FUNCT_W   = 6;
   localparam int unsigned RD_W      = 4;
   localparam int unsigned CMD_W     = 4;
   localparam int unsigned IMM_SRC_W = 2;
   localparam int unsigned REG_SRC_W = 2;
   localparam int unsigned ALU_CTL_W = 2;
   localparam int unsigned FLAG_W_W  = 2;

   localparam logic [OP_W-1:0] OP_DP  = 2'b00;
   localparam logic [OP_W-1:0] OP_MEM = 2'b01;
   localparam logic [OP_W-1:0] OP_BR  = 2'b10;

   localparam logic [CMD_W-1:0] CMD_AND = 4'b0000;
   localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
   localparam logic [CMD_W-1:0] CMD_ADD = 4'b0100;
   localparam logic [CMD_W-1:0] CMD_ORR = 4'b1100;
   localparam logic [CMD_W-1:0] CMD_CMP = 4'b1010;

   localparam logic [ALU_CTL_W-1:0] ALU_ADD = 2'b00;
   localparam logic [ALU_CTL_W-1:0] ALU_SUB = 2'b01;
   localparam logic [ALU_CTL_W-1:0] ALU_AND = 2'b10;
   localparam logic [ALU_CTL_W-1:0] ALU_ORR = 2'b11;

   localparam logic [IMM_SRC_W-1:0] IMM_8  = 2'b00;
   localparam logic [IMM_SRC_W-1:0] IMM_12 = 2'b01;
   localparam logic [IMM_SRC_W-1:0] IMM_24 = 2'b10;

   localparam logic [RD_W-1:0] R15 = 4'b1111;

   // Main-decoder control bundle, in the column order of the decode table.
   typedef struct packed {
      logic [REG_SRC_W-1:0] reg_src;
      logic [IMM_SRC_W-1:0] imm_src;
      logic                 alu_src;
      logic                 mem_to_reg;
      logic                 reg_w;
      logic                 mem_w;
      logic                 branch;
      logic                 alu_op;
   } main_ctrl_t;

   function automatic logic cmd_supported(input logic [CMD_W-1:0] cmd);
      return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
             (cmd == CMD_ORR) || (cmd == CMD_CMP);
   endfunction

endpackage

// File: rtl/arm_alu_decoder.sv
// Combinational ALU decode: maps cmd/S of data-processing instructions to
// ALU operation, flag-write enables and the compare NoWrite indication.
module arm_alu_decoder
   import arm_pkg::*;
(
   input  logic                 ALUOp,
   input  logic [4:0]           Funct,
   output logic [ALU_CTL_W-1:0] ALUControl,
   output logic [FLAG_W_W-1:0]  FlagW,
   output logic                 NoWrite
);

   logic [CMD_W-1:0] cmd;
   logic             s;

   assign cmd = Funct[4:1];
   assign s   = Funct[0];

   // Arithmetic ops update all flags on S; logical ops update only N,Z.
   always_comb begin
      ALUControl = ALU_ADD;
      FlagW      = '0;
      NoWrite    = 1'b0;
      if (ALUOp) begin
         unique case (cmd)
            CMD_ADD: begin
               ALUControl = ALU_ADD;
               FlagW      = s ? 2'b11 : 2'b00;
            end
            CMD_SUB: begin
               ALUControl = ALU_SUB;
               FlagW      = s ? 2'b11 : 2'b00;
            end
            CMD_AND: begin
               ALUControl = ALU_AND;
               FlagW      = s ? 2'b10 : 2'b00;
            end
            CMD_ORR: begin
               ALUControl = ALU_ORR;
               FlagW      = s ? 2'b10 : 2'b00;
            end
            CMD_CMP: begin
               ALUControl = ALU_SUB;
               FlagW      = 2'b11;
               NoWrite    = 1'b1;
            end
            default: begin
               ALUControl = ALU_ADD;
               FlagW      = '0;
               NoWrite    = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/arm_decoder.sv
// Registered control decoder for the single-cycle ARM-subset datapath.
// Define DECODER_ILLEGAL_EN to add the Illegal output and squash side effects.
module arm_decoder
   import arm_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [OP_W-1:0]      Op,
   input  logic [FUNCT_W-1:0]   Funct,
   input  logic [RD_W-1:0]      Rd,
   output logic                 PCS,
   output logic                 RegW,
   output logic                 MemW,
   output logic                 MemToReg,
   output logic                 ALUSrc,
   output logic                 NoWrite,
   output logic [IMM_SRC_W-1:0] ImmSrc,
   output logic [REG_SRC_W-1:0] RegSrc,
   output logic [ALU_CTL_W-1:0] ALUControl,
   output logic [FLAG_W_W-1:0]  FlagW
`ifdef DECODER_ILLEGAL_EN
   ,
   output logic                 Illegal
`endif
);

   main_ctrl_t           ctrl_c;
   logic [ALU_CTL_W-1:0] alu_ctl_c;
   logic [FLAG_W_W-1:0]  flag_w_c;
   logic                 no_write_c;
   logic                 pcs_c;
   logic                 reg_w_c;
   logic                 mem_w_c;
   logic [FLAG_W_W-1:0]  flag_w_out_c;

   // Main decode by instruction class; Op=11 leaves every control at 0.
   always_comb begin
      ctrl_c = '0;
      unique case (Op)
         OP_DP: begin
            ctrl_c.alu_src = Funct[5];
            ctrl_c.reg_w   = 1'b1;
            ctrl_c.alu_op  = 1'b1;
         end
         OP_MEM: begin
            ctrl_c.imm_src = IMM_12;
            ctrl_c.alu_src = 1'b1;
            if (Funct[0]) begin
               ctrl_c.mem_to_reg = 1'b1;
               ctrl_c.reg_w      = 1'b1;
            end else begin
               ctrl_c.reg_src = 2'b10;
               ctrl_c.mem_w   = 1'b1;
            end
         end
         OP_BR: begin
            ctrl_c.reg_src = 2'b01;
            ctrl_c.imm_src = IMM_24;
            ctrl_c.alu_src = 1'b1;
            ctrl_c.branch  = 1'b1;
         end
         default: ctrl_c = '0;
      endcase
   end

   arm_alu_decoder u_alu_dec (
      .ALUOp      (ctrl_c.alu_op),
      .Funct      (Funct[4:0]),
      .ALUControl (alu_ctl_c),
      .FlagW      (flag_w_c),
      .NoWrite    (no_write_c)
   );

   // PC is redirected by branches and by any register write targeting R15.
   assign pcs_c = ((Rd == R15) && ctrl_c.reg_w) || ctrl_c.branch;

`ifdef DECODER_ILLEGAL_EN
   logic illegal_c;

   assign illegal_c    = (Op == 2'b11) ||
                         ((Op == OP_DP) && !cmd_supported(Funct[4:1]));
   assign reg_w_c      = ctrl_c.reg_w & ~illegal_c;
   assign mem_w_c      = ctrl_c.mem_w & ~illegal_c;
   assign flag_w_out_c = illegal_c ? '0 : flag_w_c;

   always_ff @(posedge clk) begin
      if (reset) Illegal <= 1'b0;
      else       Illegal <= illegal_c;
   end
`else
   logic illegal_c;

   assign illegal_c    = 1'b0;
   assign reg_w_c      = ctrl_c.reg_w;
   assign mem_w_c      = ctrl_c.mem_w;
   assign flag_w_out_c = flag_w_c;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         PCS        <= 1'b0;
         RegW       <= 1'b0;
         MemW       <= 1'b0;
         MemToReg   <= 1'b0;
         ALUSrc     <= 1'b0;
         NoWrite    <= 1'b0;
         ImmSrc     <= '0;
         RegSrc     <= '0;
         ALUControl <= '0;
         FlagW      <= '0;
      end else begin
         PCS        <= pcs_c & ~illegal_c;
         RegW       <= reg_w_c;
         MemW       <= mem_w_c;
         MemToReg   <= ctrl_c.mem_to_reg;
         ALUSrc     <= ctrl_c.alu_src;
         NoWrite    <= no_write_c;
         ImmSrc     <= ctrl_c.imm_src;
         RegSrc     <= ctrl_c.reg_src;
         ALUControl <= alu_ctl_c;
         FlagW      <= flag_w_out_c;
      end
   end

endmodule

// File: tb/tb_arm_decoder.sv
// Self-checking bench for arm_decoder: directed vector table, hand-written
// latency/reset sequences, and randomized instructions against a reference model.
module tb_arm_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic       PCS, RegW, MemW, MemToReg, ALUSrc, NoWrite;
   logic [1:0] ImmSrc, RegSrc, ALUControl, FlagW;
   logic       ill_bit;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   arm_decoder dut (
      .clk        (clk),
      .reset      (reset),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .PCS        (PCS),
      .RegW       (RegW),
      .MemW       (MemW),
      .MemToReg   (MemToReg),
      .ALUSrc     (ALUSrc),
      .NoWrite    (NoWrite),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl),
      .FlagW      (FlagW)
`ifdef DECODER_ILLEGAL_EN
      ,
      .Illegal    (ill_bit)
`endif
   );

`ifndef DECODER_ILLEGAL_EN
   assign ill_bit = 1'b0;
`endif

   // Observed outputs: {Illegal, PCS, RegW, MemW, MemToReg, ALUSrc, NoWrite,
   //                    ImmSrc, RegSrc, ALUControl, FlagW}
   logic [14:0] dut_vec;
   assign dut_vec = {ill_bit, PCS, RegW, MemW, MemToReg, ALUSrc, NoWrite,
                     ImmSrc, RegSrc, ALUControl, FlagW};

   function automatic logic [13:0] mk(input bit pcs, input bit regw, input bit memw,
                                      input bit m2r, input bit alusrc, input bit nw,
                                      input logic [1:0] imm, input logic [1:0] regsrc,
                                      input logic [1:0] alu, input logic [1:0] fw);
      return {pcs, regw, memw, m2r, alusrc, nw, imm, regsrc, alu, fw};
   endfunction

   // Applies the optional illegal-instruction squash to a base expectation.
   function automatic logic [14:0] with_ill(input logic [13:0] e, input bit ill);
`ifdef DECODER_ILLEGAL_EN
      if (ill) begin
         e[13]  = 1'b0;
         e[12]  = 1'b0;
         e[11]  = 1'b0;
         e[1:0] = 2'b00;
      end
      return {ill, e};
`else
      return {1'b0, e};
`endif
   endfunction

   // Reference model built from the instruction-class and command rules.
   function automatic logic [14:0] model(input logic [1:0] op, input logic [5:0] f,
                                         input logic [3:0] rd);
      bit         pcs = 0, regw = 0, memw = 0, m2r = 0, alusrc = 0, nw = 0, br = 0;
      bit         ill = 0;
      logic [1:0] imm = 0, regsrc = 0, alu = 0, fw = 0;
      logic [3:0] cmd = f[4:1];
      bit         s   = f[0];
      if (op == 2'd0) begin
         regw   = 1;
         alusrc = f[5];
         if      (cmd == 4'd4)  begin alu = 2'd0; fw = s ? 2'd3 : 2'd0; end
         else if (cmd == 4'd2)  begin alu = 2'd1; fw = s ? 2'd3 : 2'd0; end
         else if (cmd == 4'd0)  begin alu = 2'd2; fw = s ? 2'd2 : 2'd0; end
         else if (cmd == 4'd12) begin alu = 2'd3; fw = s ? 2'd2 : 2'd0; end
         else if (cmd == 4'd10) begin alu = 2'd1; fw = 2'd3; nw = 1; end
         else ill = 1;
      end else if (op == 2'd1) begin
         imm = 2'd1; alusrc = 1;
         if (s) begin regw = 1; m2r = 1; end
         else   begin memw = 1; regsrc = 2'd2; end
      end else if (op == 2'd2) begin
         br = 1; imm = 2'd2; regsrc = 2'd1; alusrc = 1;
      end else begin
         ill = 1;
      end
      pcs = br || (regw && rd == 4'd15);
      return with_ill(mk(pcs, regw, memw, m2r, alusrc, nw, imm, regsrc, alu, fw), ill);
   endfunction

   task automatic check(input string name, input logic [14:0] exp);
      n_checks++;
      if (dut_vec !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (Op=%b Funct=%b Rd=%0d)",
                  name, dut_vec, exp, Op, Funct, Rd);
      end
   endtask

   task automatic drive(input bit rst, input logic [1:0] op, input logic [5:0] f,
                        input logic [3:0] rd);
      @(negedge clk);
      reset = rst; Op = op; Funct = f; Rd = rd;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string      name;
      bit         rst;
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd;
      bit         ill;
      logic [13:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input bit rst, input logic [1:0] op,
                      input logic [5:0] f, input logic [3:0] rd, input bit ill,
                      input logic [13:0] exp);
      vec_t v;
      v.name = name; v.rst = rst; v.op = op; v.funct = f; v.rd = rd;
      v.ill = ill; v.exp = exp;
      vecs.push_back(v);
   endtask

   logic [14:0] e;

   initial begin
      reset = 1'b1; Op = 2'b00; Funct = 6'b0; Rd = 4'd0;

      add("reset",     1, 2'd0, 6'b000000, 4'd0,  0, 14'h0);
      add("and_reg",   0, 2'd0, 6'b000000, 4'd0,  0, mk(0,1,0,0,0,0,2'b00,2'b00,2'b10,2'b00));
      add("adds_imm",  0, 2'd0, 6'b101001, 4'd0,  0, mk(0,1,0,0,1,0,2'b00,2'b00,2'b00,2'b11));
      add("str",       0, 2'd1, 6'b000000, 4'd0,  0, mk(0,0,1,0,1,0,2'b01,2'b10,2'b00,2'b00));
      add("str_r15",   0, 2'd1, 6'b000000, 4'd15, 0, mk(0,0,1,0,1,0,2'b01,2'b10,2'b00,2'b00));
      add("ldr",       0, 2'd1, 6'b000001, 4'd0,  0, mk(0,1,0,1,1,0,2'b01,2'b00,2'b00,2'b00));
      add("ldr_r15",   0, 2'd1, 6'b000001, 4'd15, 0, mk(1,1,0,1,1,0,2'b01,2'b00,2'b00,2'b00));
      add("branch",    0, 2'd2, 6'b000000, 4'd0,  0, mk(1,0,0,0,1,0,2'b10,2'b01,2'b00,2'b00));
      add("branch_f",  0, 2'd2, 6'b111111, 4'd15, 0, mk(1,0,0,0,1,0,2'b10,2'b01,2'b00,2'b00));
      add("cmp_s",     0, 2'd0, 6'b010101, 4'd3,  0, mk(0,1,0,0,0,1,2'b00,2'b00,2'b01,2'b11));
      add("cmp_nos",   0, 2'd0, 6'b010100, 4'd3,  0, mk(0,1,0,0,0,1,2'b00,2'b00,2'b01,2'b11));
      add("sub",       0, 2'd0, 6'b000100, 4'd2,  0, mk(0,1,0,0,0,0,2'b00,2'b00,2'b01,2'b00));
      add("subs_imm",  0, 2'd0, 6'b100101, 4'd2,  0, mk(0,1,0,0,1,0,2'b00,2'b00,2'b01,2'b11));
      add("orrs",      0, 2'd0, 6'b011001, 4'd4,  0, mk(0,1,0,0,0,0,2'b00,2'b00,2'b11,2'b10));
      add("ands",      0, 2'd0, 6'b000001, 4'd4,  0, mk(0,1,0,0,0,0,2'b00,2'b00,2'b10,2'b10));
      add("add_r15",   0, 2'd0, 6'b001000, 4'd15, 0, mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00));
      add("op11",      0, 2'd3, 6'b111111, 4'd15, 1, 14'h0);
      add("eor_undef", 0, 2'd0, 6'b000010, 4'd1,  1, mk(0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00));
      add("eors_r15",  0, 2'd0, 6'b000011, 4'd15, 1, mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].rd);
         check(vecs[i].name, with_ill(vecs[i].exp, vecs[i].ill));
      end

      // One-cycle latency: input changes between edges do not reach the outputs.
      drive(0, 2'd0, 6'b101001, 4'd0);
      e = with_ill(mk(0,1,0,0,1,0,2'b00,2'b00,2'b00,2'b11), 0);
      check("lat_first", e);
      Op = 2'd2; Funct = 6'b000000; Rd = 4'd0;
      #2;
      check("lat_hold", e);
      @(posedge clk); #1;
      check("lat_next", with_ill(mk(1,0,0,0,1,0,2'b10,2'b01,2'b00,2'b00), 0));

      // Reset asserted while a CMP is being decoded discards it.
      drive(0, 2'd0, 6'b010101, 4'd0);
      check("cmp_before_rst", with_ill(mk(0,1,0,0,0,1,2'b00,2'b00,2'b01,2'b11), 0));
      drive(1, 2'd0, 6'b010101, 4'd0);
      check("cmp_rst", 15'h0);
      drive(0, 2'd2, 6'b000000, 4'd0);
      check("after_rst_branch", with_ill(mk(1,0,0,0,1,0,2'b10,2'b01,2'b00,2'b00), 0));

      // Randomized instruction stream with occasional reset.
      for (int i = 0; i < 500; i++) begin
         logic       r;
         logic [1:0] op;
         logic [5:0] f;
         logic [3:0] rd;
         r  = ($urandom_range(0, 15) == 0);
         op = 2'($urandom);
         f  = 6'($urandom);
         rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
         drive(r, op, f, rd);
         check("random", r ? 15'h0 : model(op, f, rd));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
